// File: rtl/stepper_ramp_driver.sv
// Four-phase unipolar stepper driver with step-count targets, full/half-step drive,
// a linear accel/decel divider ramp, abort, optional holding torque and position tracking.
module stepper_ramp_driver #(
    parameter int unsigned DIV_W     = 24,
    parameter int unsigned START_DIV = 260000,
    parameter int unsigned MIN_DIV   = 130000,
    parameter int unsigned RAMP      = 2000,
    parameter int unsigned STEP_W    = 16,
    parameter int unsigned POS_W     = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    start_i,
    input  logic                    abort_i,
    input  logic                    dir_i,
    input  logic                    half_i,
    input  logic                    hold_i,
    input  logic [STEP_W-1:0]       steps_i,
    output logic [3:0]              coil_o,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    aborted_o,
    output logic signed [POS_W-1:0] pos_o
);

    localparam logic [0:0] StIdle = 1'b0;
    localparam logic [0:0] StRun  = 1'b1;

    localparam logic [DIV_W-1:0] StartDiv = DIV_W'(START_DIV);
    localparam logic [DIV_W-1:0] MinDiv   = DIV_W'(MIN_DIV);
    localparam logic [DIV_W-1:0] RampDiv  = DIV_W'(RAMP);

    logic [0:0]              state_q, state_d;
    logic [2:0]              idx_q, idx_d;
    logic signed [POS_W-1:0] pos_q, pos_d;
    logic [STEP_W-1:0]       rem_q, rem_d;
    logic [STEP_W-1:0]       ramp_n_q, ramp_n_d;
    logic [DIV_W-1:0]        div_q, div_d;
    logic [DIV_W-1:0]        timer_q, timer_d;
    logic                    dir_q, dir_d;
    logic                    half_q, half_d;
    logic [3:0]              coil_q, coil_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    aborted_q, aborted_d;

    logic [2:0]              idx_step;
    logic signed [POS_W-1:0] pos_step;
    logic [STEP_W-1:0]       rem_dec;
    logic                    tick;

    function automatic logic [3:0] phase_pattern(input logic [2:0] idx);
        logic [3:0] pat;
        case (idx)
            3'd0:    pat = 4'b0001;
            3'd1:    pat = 4'b0011;
            3'd2:    pat = 4'b0010;
            3'd3:    pat = 4'b0110;
            3'd4:    pat = 4'b0100;
            3'd5:    pat = 4'b1100;
            3'd6:    pat = 4'b1000;
            default: pat = 4'b1001;
        endcase
        return pat;
    endfunction

    assign idx_step = half_q ? 3'd1 : 3'd2;
    assign pos_step = half_q ? POS_W'(1) : POS_W'(2);
    assign rem_dec  = rem_q - STEP_W'(1);
    assign tick     = (timer_q == div_q - DIV_W'(1));

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        pos_d     = pos_q;
        rem_d     = rem_q;
        ramp_n_d  = ramp_n_q;
        div_d     = div_q;
        timer_d   = timer_q;
        dir_d     = dir_q;
        half_d    = half_q;
        done_d    = 1'b0;
        aborted_d = 1'b0;

        case (state_q)
            StIdle: begin
                if (start_i && !abort_i) begin
                    if (steps_i != '0) begin
                        state_d  = StRun;
                        dir_d    = dir_i;
                        half_d   = half_i;
                        rem_d    = steps_i;
                        div_d    = StartDiv;
                        timer_d  = '0;
                        ramp_n_d = '0;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            StRun: begin
                // Abort outranks a tick on the same edge: no step is taken.
                if (abort_i) begin
                    state_d   = StIdle;
                    aborted_d = 1'b1;
                end else if (tick) begin
                    idx_d   = dir_q ? idx_q + idx_step : idx_q - idx_step;
                    pos_d   = dir_q ? pos_q + pos_step : pos_q - pos_step;
                    rem_d   = rem_dec;
                    timer_d = '0;
                    if (rem_dec == '0) begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end else if (rem_dec <= ramp_n_q) begin
                        // Clamp before adding so the divider never wraps.
                        div_d    = (StartDiv - div_q <= RampDiv) ? StartDiv : div_q + RampDiv;
                        ramp_n_d = (ramp_n_q == '0) ? '0 : ramp_n_q - STEP_W'(1);
                    end else if (div_q > MinDiv) begin
                        div_d    = (div_q - MinDiv <= RampDiv) ? MinDiv : div_q - RampDiv;
                        ramp_n_d = ramp_n_q + STEP_W'(1);
                    end
                end else begin
                    timer_d = timer_q + DIV_W'(1);
                end
            end
            default: state_d = StIdle;
        endcase

        busy_d = (state_d == StRun);
        coil_d = (busy_d || hold_i) ? phase_pattern(idx_d) : 4'b0000;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= StIdle;
            idx_q     <= '0;
            pos_q     <= '0;
            rem_q     <= '0;
            ramp_n_q  <= '0;
            div_q     <= StartDiv;
            timer_q   <= '0;
            dir_q     <= 1'b0;
            half_q    <= 1'b0;
            coil_q    <= 4'b0000;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            pos_q     <= pos_d;
            rem_q     <= rem_d;
            ramp_n_q  <= ramp_n_d;
            div_q     <= div_d;
            timer_q   <= timer_d;
            dir_q     <= dir_d;
            half_q    <= half_d;
            coil_q    <= coil_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            aborted_q <= aborted_d;
        end
    end

    assign coil_o    = coil_q;
    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign aborted_o = aborted_q;
    assign pos_o     = pos_q;

endmodule

// File: tb/tb_stepper_ramp_driver.sv
// Directed bench for stepper_ramp_driver with a short divider ramp (10 -> 4, step 2).
module tb_stepper_ramp_driver;

    logic               clk_i = 1'b0;
    logic               rst_i = 1'b1;
    logic               start_i = 1'b0;
    logic               abort_i = 1'b0;
    logic               dir_i = 1'b0;
    logic               half_i = 1'b0;
    logic               hold_i = 1'b0;
    logic [15:0]        steps_i = '0;
    logic [3:0]         coil_o;
    logic               busy_o;
    logic               done_o;
    logic               aborted_o;
    logic signed [31:0] pos_o;

    int n_checks = 0;
    int n_fail   = 0;

    int         iv[0:63];
    logic [3:0] cs[0:63];
    int         nsteps;

    stepper_ramp_driver #(
        .DIV_W(24), .START_DIV(10), .MIN_DIV(4), .RAMP(2), .STEP_W(16), .POS_W(32)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .abort_i(abort_i),
        .dir_i(dir_i), .half_i(half_i), .hold_i(hold_i), .steps_i(steps_i),
        .coil_o(coil_o), .busy_o(busy_o), .done_o(done_o), .aborted_o(aborted_o),
        .pos_o(pos_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick_cycle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset(input int n);
        rst_i = 1'b1;
        repeat (n) tick_cycle();
        rst_i = 1'b0;
    endtask

    task automatic pulse_start(input logic [15:0] s, input logic d, input logic h,
                               input logic hd);
        start_i = 1'b1;
        steps_i = s;
        dir_i   = d;
        half_i  = h;
        hold_i  = hd;
        tick_cycle();
        start_i = 1'b0;
    endtask

    // Returns in the done cycle; records each step interval and the coil after each step.
    task automatic run_move(input logic [15:0] s, input logic d, input logic h,
                            input logic hd, input logic [3:0] first_coil);
        int         cnt;
        logic       fin;
        logic [3:0] last;
        pulse_start(s, d, h, hd);
        check_eq("busy_at_start", 32'(busy_o), 32'd1);
        check_eq("coil_at_start", 32'(coil_o), 32'(first_coil));
        nsteps = 0;
        cnt    = 0;
        fin    = 1'b0;
        last   = coil_o;
        for (int c = 0; c < 3000 && !fin; c++) begin
            tick_cycle();
            cnt++;
            if (done_o || coil_o != last) begin
                if (nsteps < 64) begin
                    iv[nsteps] = cnt;
                    cs[nsteps] = coil_o;
                end
                nsteps++;
                last = coil_o;
                cnt  = 0;
                fin  = done_o;
            end
        end
        check_eq("move_completed", 32'(fin), 32'd1);
    endtask

    task automatic wait_step(input logic [3:0] prev, output int cyc);
        cyc = 0;
        do begin
            tick_cycle();
            cyc++;
        end while (coil_o == prev && cyc < 200);
        check_eq("step_seen", 32'(coil_o != prev), 32'd1);
    endtask

    int         exp20[20] = '{10, 8, 6, 4, 4, 4, 4, 4, 4, 4, 4, 4, 4, 4, 4, 4, 4, 6, 8, 10};
    int         exp4[4]   = '{10, 8, 6, 8};
    logic [3:0] cs4[4]    = '{4'b0010, 4'b0100, 4'b1000, 4'b0000};
    int         exp3[3]   = '{10, 8, 10};
    logic [3:0] cs3[3]    = '{4'b1001, 4'b1000, 4'b1100};

    initial begin
        int cyc;
        tick_cycle();
        do_reset(2);
        check_eq("rst_coil", 32'(coil_o), 32'h0);
        check_eq("rst_busy", 32'(busy_o), 32'd0);
        check_eq("rst_done", 32'(done_o), 32'd0);
        check_eq("rst_aborted", 32'(aborted_o), 32'd0);
        check_eq("rst_pos", pos_o, 32'd0);

        // Reset mid-move
        pulse_start(16'd100, 1'b1, 1'b0, 1'b1);
        repeat (25) tick_cycle();
        check_eq("midmove_busy", 32'(busy_o), 32'd1);
        rst_i = 1'b1;
        tick_cycle();
        check_eq("midrst_coil", 32'(coil_o), 32'h0);
        check_eq("midrst_busy", 32'(busy_o), 32'd0);
        check_eq("midrst_pos", pos_o, 32'd0);
        repeat (2) tick_cycle();
        rst_i  = 1'b0;
        hold_i = 1'b0;
        tick_cycle();
        check_eq("post_rst_coil", 32'(coil_o), 32'h0);

        // Full-step forward, 4 steps
        run_move(16'd4, 1'b1, 1'b0, 1'b0, 4'b0001);
        check_eq("full4_nsteps", nsteps, 32'd4);
        for (int k = 0; k < 4; k++) begin
            check_eq($sformatf("full4_iv%0d", k), iv[k], exp4[k]);
            check_eq($sformatf("full4_coil%0d", k), 32'(cs[k]), 32'(cs4[k]));
        end
        check_eq("full4_done_busy", 32'(busy_o), 32'd0);
        check_eq("full4_pos", pos_o, 32'd8);
        tick_cycle();
        check_eq("full4_done_once", 32'(done_o), 32'd0);

        // Half-step reverse with hold
        do_reset(1);
        run_move(16'd3, 1'b0, 1'b1, 1'b1, 4'b0001);
        check_eq("half3_nsteps", nsteps, 32'd3);
        for (int k = 0; k < 3; k++) begin
            check_eq($sformatf("half3_iv%0d", k), iv[k], exp3[k]);
            check_eq($sformatf("half3_coil%0d", k), 32'(cs[k]), 32'(cs3[k]));
        end
        check_eq("half3_pos", pos_o, 32'hFFFF_FFFD);
        repeat (5) tick_cycle();
        check_eq("half3_hold_coil", 32'(coil_o), 32'b1100);
        hold_i = 1'b0;
        tick_cycle();
        check_eq("hold_release_coil", 32'(coil_o), 32'h0);

        // Full-step 20 steps through accel, cruise and decel
        do_reset(1);
        run_move(16'd20, 1'b1, 1'b0, 1'b0, 4'b0001);
        check_eq("full20_nsteps", nsteps, 32'd20);
        for (int k = 0; k < 20; k++) begin
            check_eq($sformatf("full20_iv%0d", k), iv[k], exp20[k]);
        end
        check_eq("full20_last_coil", 32'(cs[19]), 32'h0);
        check_eq("full20_pos", pos_o, 32'd40);
        tick_cycle();
        check_eq("full20_done_once", 32'(done_o), 32'd0);

        // Abort one cycle after the second step; an intervening start is ignored
        do_reset(1);
        pulse_start(16'd100, 1'b1, 1'b0, 1'b0);
        wait_step(4'b0001, cyc);
        check_eq("abort_iv0", cyc, 32'd10);
        check_eq("abort_coil0", 32'(coil_o), 32'b0010);
        pulse_start(16'd0, 1'b0, 1'b1, 1'b0);
        check_eq("ignored_start_done", 32'(done_o), 32'd0);
        check_eq("ignored_start_busy", 32'(busy_o), 32'd1);
        wait_step(4'b0010, cyc);
        check_eq("abort_coil1", 32'(coil_o), 32'b0100);
        abort_i = 1'b1;
        tick_cycle();
        abort_i = 1'b0;
        check_eq("abort_pulse", 32'(aborted_o), 32'd1);
        check_eq("abort_busy", 32'(busy_o), 32'd0);
        check_eq("abort_done", 32'(done_o), 32'd0);
        check_eq("abort_pos", pos_o, 32'd4);
        check_eq("abort_coil", 32'(coil_o), 32'h0);
        tick_cycle();
        check_eq("abort_once", 32'(aborted_o), 32'd0);
        check_eq("abort_no_done", 32'(done_o), 32'd0);

        // Zero-step move
        pulse_start(16'd0, 1'b1, 1'b0, 1'b0);
        check_eq("zero_done", 32'(done_o), 32'd1);
        check_eq("zero_busy", 32'(busy_o), 32'd0);
        tick_cycle();
        check_eq("zero_done_once", 32'(done_o), 32'd0);
        check_eq("zero_busy2", 32'(busy_o), 32'd0);
        check_eq("zero_pos", pos_o, 32'd4);
        check_eq("zero_coil", 32'(coil_o), 32'h0);

        // start and abort together in idle
        abort_i = 1'b1;
        pulse_start(16'd5, 1'b1, 1'b0, 1'b0);
        abort_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check_eq($sformatf("startabort_busy%0d", k), 32'(busy_o), 32'd0);
            check_eq($sformatf("startabort_done%0d", k), 32'(done_o), 32'd0);
            check_eq($sformatf("startabort_abt%0d", k), 32'(aborted_o), 32'd0);
            tick_cycle();
        end
        check_eq("startabort_pos", pos_o, 32'd4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
